// File: rtl/fb_text_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_text_pkg - frame-buffer geometry, control codes and writer FSM states
// Revision: 1.0
// ---------------------------------------------------------------------------
package fb_text_pkg;

  localparam logic [15:0] FB_BASE     = 16'hF000;
  localparam logic [15:0] ROW_STRIDE  = 16'd80;
  localparam int          COLS        = 80;
  localparam int          ROWS        = 60;
  localparam logic [7:0]  BLANK_GLYPH = 8'h20;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [5:0] ROW_LAST  = 6'(ROWS - 1);
  localparam logic [5:0] WORD_LAST = 6'(COLS / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_CLR
`ifdef FB_TEXT_WRITER_SCROLL_EN
    ,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_SCR_CLR
`endif
  } fb_state_e;

  // Word address of a glyph row/word pair; wraps at 16 bits by construction.
  function automatic logic [15:0] cell_addr(input logic [5:0] row, input logic [5:0] word);
    return FB_BASE + ROW_STRIDE * {10'd0, row} + {10'd0, word};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_cursor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_cursor - 80x60 glyph cursor with end-of-screen detect
// Build option: FB_TEXT_WRITER_SCROLL_EN (row holds at the last row for scroll)
// Revision: 1.0
// ---------------------------------------------------------------------------
module fb_cursor (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_advance,
  input  logic       i_newline,
  input  logic       i_carriage_return,
  input  logic       i_backspace,
  input  logic       i_home,
  output logic [6:0] o_col,
  output logic [5:0] o_row,
  output logic       o_eos
);
  import fb_text_pkg::*;

  logic [6:0] r_col;
  logic [5:0] r_row;
  logic       w_col_wrap;
  logic       w_row_adv;

  assign w_col_wrap = i_advance && (r_col == COL_LAST);
  assign w_row_adv  = i_newline || w_col_wrap;
  assign o_eos      = w_row_adv && (r_row == ROW_LAST);
  assign o_col      = r_col;
  assign o_row      = r_row;

  always_ff @(posedge clk) begin
    if (reset || i_home) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (i_newline || i_carriage_return || w_col_wrap)
        r_col <= '0;
      else if (i_advance)
        r_col <= r_col + 7'd1;
      else if (i_backspace && (r_col != '0))
        r_col <= r_col - 7'd1;

      if (w_row_adv) begin
        if (r_row != ROW_LAST)
          r_row <= r_row + 6'd1;
`ifndef FB_TEXT_WRITER_SCROLL_EN
        else
          r_row <= '0;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_text_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_text_writer - character stream to text-mode frame buffer via read-modify-write
// Build option: FB_TEXT_WRITER_SCROLL_EN (scroll up at end of screen instead of wrap)
// Revision: 1.0
// ---------------------------------------------------------------------------
module fb_text_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_char_valid,
  input  logic [7:0]  i_char_data,
  output logic        o_char_ready,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic [15:0] i_mem_rdata,
  output logic        o_busy,
  output logic [6:0]  o_cursor_col,
  output logic [5:0]  o_cursor_row
);
  import fb_text_pkg::*;

  fb_state_e  r_state, w_state_n;
  logic [7:0] r_code;
  logic [5:0] r_row_idx, r_word_idx;
  logic       w_accept, w_is_lf, w_is_cr, w_is_bs, w_is_ff, w_is_glyph;
  logic       w_advance, w_eos, w_word_last, w_idx_step, w_idx_clear;

  assign o_char_ready = (r_state == ST_IDLE) && !reset;
  assign o_busy       = (r_state != ST_IDLE);
  assign w_accept     = i_char_valid && o_char_ready;
  assign w_is_lf      = w_accept && (i_char_data == CH_LF);
  assign w_is_cr      = w_accept && (i_char_data == CH_CR);
  assign w_is_bs      = w_accept && (i_char_data == CH_BS);
  assign w_is_ff      = w_accept && (i_char_data == CH_FF);
  assign w_is_glyph   = w_accept && !(w_is_lf || w_is_cr || w_is_bs || w_is_ff);
  assign w_advance    = (r_state == ST_WR);
  assign w_word_last  = (r_word_idx == WORD_LAST);

  fb_cursor u_cursor (
    .clk               (clk),
    .reset             (reset),
    .i_advance         (w_advance),
    .i_newline         (w_is_lf),
    .i_carriage_return (w_is_cr),
    .i_backspace       (w_is_bs),
    .i_home            (w_is_ff),
    .o_col             (o_cursor_col),
    .o_row             (o_cursor_row),
    .o_eos             (w_eos)
  );

`ifndef FB_TEXT_WRITER_SCROLL_EN
  logic w_unused_eos;
  assign w_unused_eos = w_eos;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_code     <= '0;
      r_row_idx  <= '0;
      r_word_idx <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_is_glyph)
        r_code <= i_char_data;
      if (w_idx_clear) begin
        r_row_idx  <= '0;
        r_word_idx <= '0;
      end else if (w_idx_step) begin
        r_word_idx <= w_word_last ? 6'd0 : r_word_idx + 6'd1;
        if (w_word_last)
          r_row_idx <= r_row_idx + 6'd1;
      end
    end
  end

  always_comb begin
    w_state_n   = r_state;
    o_mem_addr  = FB_BASE;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    w_idx_clear = 1'b0;
    w_idx_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_ff) begin
          w_state_n   = ST_CLR;
          w_idx_clear = 1'b1;
        end else if (w_is_glyph) begin
          w_state_n = ST_RD;
        end
`ifdef FB_TEXT_WRITER_SCROLL_EN
        else if (w_is_lf && w_eos) begin
          w_state_n   = ST_SCR_RD;
          w_idx_clear = 1'b1;
        end
`endif
      end
      ST_RD: begin
        o_mem_addr = cell_addr(o_cursor_row, o_cursor_col[6:1]);
        w_state_n  = ST_WR;
      end
      ST_WR: begin
        // Cursor still points at the target cell until this edge.
        o_mem_addr  = cell_addr(o_cursor_row, o_cursor_col[6:1]);
        o_mem_wdata = o_cursor_col[0] ? {i_mem_rdata[15:8], r_code}
                                      : {r_code, i_mem_rdata[7:0]};
        o_mem_we    = 1'b1;
        w_state_n   = ST_IDLE;
`ifdef FB_TEXT_WRITER_SCROLL_EN
        if (w_eos) begin
          w_state_n   = ST_SCR_RD;
          w_idx_clear = 1'b1;
        end
`endif
      end
      ST_CLR: begin
        o_mem_addr  = cell_addr(r_row_idx, r_word_idx);
        o_mem_wdata = {BLANK_GLYPH, BLANK_GLYPH};
        o_mem_we    = 1'b1;
        w_idx_step  = 1'b1;
        if (w_word_last && (r_row_idx == ROW_LAST))
          w_state_n = ST_IDLE;
      end
`ifdef FB_TEXT_WRITER_SCROLL_EN
      ST_SCR_RD: begin
        o_mem_addr = cell_addr(r_row_idx + 6'd1, r_word_idx);
        w_state_n  = ST_SCR_WR;
      end
      ST_SCR_WR: begin
        o_mem_addr  = cell_addr(r_row_idx, r_word_idx);
        o_mem_wdata = i_mem_rdata;
        o_mem_we    = 1'b1;
        w_idx_step  = 1'b1;
        w_state_n   = (w_word_last && (r_row_idx == ROW_LAST - 6'd1)) ? ST_SCR_CLR : ST_SCR_RD;
      end
      ST_SCR_CLR: begin
        o_mem_addr  = cell_addr(r_row_idx, r_word_idx);
        o_mem_wdata = {BLANK_GLYPH, BLANK_GLYPH};
        o_mem_we    = 1'b1;
        w_idx_step  = 1'b1;
        if (w_word_last)
          w_state_n = ST_IDLE;
      end
`endif
      default: w_state_n = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_text_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fb_text_writer - randomized bench with a glyph-grid reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fb_text_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_char_valid;
  logic [7:0]  i_char_data;
  logic        o_char_ready;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        o_mem_we;
  logic [15:0] i_mem_rdata;
  logic        o_busy;
  logic [6:0]  o_cursor_col;
  logic [5:0]  o_cursor_row;

  int checks = 0;
  int errors = 0;

  fb_text_writer dut (
    .clk          (clk),
    .reset        (reset),
    .i_char_valid (i_char_valid),
    .i_char_data  (i_char_data),
    .o_char_ready (o_char_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_we     (o_mem_we),
    .i_mem_rdata  (i_mem_rdata),
    .o_busy       (o_busy),
    .o_cursor_col (o_cursor_col),
    .o_cursor_row (o_cursor_row)
  );

  always #5 clk = ~clk;

  // Frame-buffer RAM with one-cycle read latency plus a log of every write.
  logic [15:0] ram [0:65535];
  logic [15:0] wlog_addr [0:8191];
  logic [15:0] wlog_data [0:8191];
  int          wr_count = 0;

  always @(posedge clk) begin
    if (o_mem_we) begin
      ram[o_mem_addr]                 <= o_mem_wdata;
      wlog_addr[13'(wr_count)] <= o_mem_addr;
      wlog_data[13'(wr_count)] <= o_mem_wdata;
      wr_count                        <= wr_count + 1;
    end
    i_mem_rdata <= ram[o_mem_addr];
  end

  // Reference model: the visible screen as a glyph grid plus a cursor.
  logic [7:0] scr [0:59][0:79];
  int m_col = 0;
  int m_row = 0;

  task automatic model_row_adv();
    if (m_row < 59) begin
      m_row++;
    end else begin
`ifdef FB_TEXT_WRITER_SCROLL_EN
      for (int r = 0; r < 59; r++)
        for (int c = 0; c < 80; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < 80; c++) scr[59][c] = 8'h20;
      m_row = 59;
`else
      m_row = 0;
`endif
    end
  endtask

  task automatic model_char(input logic [7:0] ch);
    case (ch)
      8'h0A: begin m_col = 0; model_row_adv(); end
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) m_col--;
      8'h0C: begin
        for (int r = 0; r < 60; r++)
          for (int c = 0; c < 80; c++) scr[r][c] = 8'h20;
        m_col = 0;
        m_row = 0;
      end
      default: begin
        scr[m_row][m_col] = ch;
        m_col++;
        if (m_col == 80) begin m_col = 0; model_row_adv(); end
      end
    endcase
  endtask

  function automatic logic [7:0] rand_glyph();
    return 8'($urandom_range(8'h21, 8'h7E));
  endfunction

  task automatic check_cursor(input string name);
    checks++;
    if (o_cursor_col !== 7'(m_col) || o_cursor_row !== 6'(m_row)) begin
      errors++;
      $display("FAIL %s: cursor (%0d,%0d) required (%0d,%0d)", name,
               o_cursor_col, o_cursor_row, m_col, m_row);
    end
  endtask

  task automatic check_screen(input string name);
    int bad = 0;
    logic [15:0] w;
    logic [7:0]  b;
    for (int r = 0; r < 60; r++) begin
      for (int c = 0; c < 80; c++) begin
        w = ram[16'(32'hF000 + 80 * r + c / 2)];
        b = (c % 2 == 1) ? w[7:0] : w[15:8];
        if (b !== scr[r][c]) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d glyph cells differ, required 0", name, bad);
    end
  endtask

  // Present one code, wait for acceptance, then wait for the block to go idle.
  task automatic send_char(input logic [7:0] ch, output int busy_cyc);
    int n = 0;
    i_char_valid = 1'b1;
    i_char_data  = ch;
    while (!o_char_ready && n < 6000) begin @(negedge clk); n++; end
    checks++;
    if (!o_char_ready) begin
      errors++;
      $display("FAIL accept_timeout: ready %0b required 1 for code %h", o_char_ready, ch);
    end
    @(negedge clk);
    i_char_valid = 1'b0;
    busy_cyc = 0;
    while (o_busy && busy_cyc < 6000) begin @(negedge clk); busy_cyc++; end
    checks++;
    if (o_busy) begin
      errors++;
      $display("FAIL busy_timeout: busy %0b required 0 after code %h", o_busy, ch);
    end
    model_char(ch);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_char_valid = 1'b0;
    i_char_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (o_char_ready !== 1'b0 || o_mem_we !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready/we/busy %b%b%b required 000", o_char_ready, o_mem_we, o_busy);
    end
    checks++;
    if (o_mem_addr !== 16'hF000 || o_mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mem: addr %h wdata %h required F000 0000", o_mem_addr, o_mem_wdata);
    end
    check_cursor("reset_cursor");
    reset = 1'b0;
    #1;
    checks++;
    if (o_char_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready %b required 1", o_char_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_backspace_home();
    int n0 = wr_count;
    int b;
    send_char(8'h08, b);
    checks++;
    if (wr_count != n0 || b != 0) begin
      errors++;
      $display("FAIL bs_home: writes %0d busy %0d required 0 0", wr_count - n0, b);
    end
    check_cursor("bs_home_cursor");
  endtask

  task automatic test_clear();
    int n0 = wr_count;
    int cyc = 0;
    int ready_hi = 0;
    int bad = 0;
    i_char_valid = 1'b1;
    i_char_data  = 8'h0C;
    @(negedge clk);
    i_char_valid = 1'b0;
    while (o_busy && cyc < 3000) begin
      if (o_char_ready) ready_hi++;
      @(negedge clk);
      cyc++;
    end
    model_char(8'h0C);
    checks++;
    if (cyc != 2400 || wr_count - n0 != 2400 || ready_hi != 0) begin
      errors++;
      $display("FAIL clear_count: cycles %0d writes %0d ready-high %0d required 2400 2400 0",
               cyc, wr_count - n0, ready_hi);
    end
    for (int k = 0; k < 2400; k++)
      if (wlog_data[13'(n0 + k)] !== 16'h2020) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_data: %0d words not 2020, required 0", bad);
    end
    check_cursor("clear_cursor");
    check_screen("clear_screen");
  endtask

  task automatic test_first_glyphs();
    int n0 = wr_count;
    int b;
    send_char(8'h41, b);
    checks++;
    if (b != 2 || wr_count - n0 != 1 || wlog_addr[13'(n0)] !== 16'hF000 || wlog_data[13'(n0)] !== 16'h4120) begin
      errors++;
      $display("FAIL glyph_41: busy %0d writes %0d addr %h data %h required 2 1 F000 4120",
               b, wr_count - n0, wlog_addr[13'(n0)], wlog_data[13'(n0)]);
    end
    check_cursor("glyph_41_cursor");
    n0 = wr_count;
    send_char(8'h42, b);
    checks++;
    if (wr_count - n0 != 1 || wlog_addr[13'(n0)] !== 16'hF000 || wlog_data[13'(n0)] !== 16'h4142) begin
      errors++;
      $display("FAIL glyph_42: writes %0d addr %h data %h required 1 F000 4142",
               wr_count - n0, wlog_addr[13'(n0)], wlog_data[13'(n0)]);
    end
    check_cursor("glyph_42_cursor");
  endtask

  task automatic test_newline_glyph();
    int n0;
    int b;
    send_char(8'h0D, b);
    repeat (3) send_char(8'h0A, b);
    repeat (5) send_char(rand_glyph(), b);
    check_cursor("at_5_3");
    n0 = wr_count;
    send_char(8'h0A, b);
    checks++;
    if (wr_count != n0) begin
      errors++;
      $display("FAIL lf_no_write: writes %0d required 0", wr_count - n0);
    end
    check_cursor("lf_cursor");
    n0 = wr_count;
    send_char(8'h43, b);
    checks++;
    if (wr_count - n0 != 1 || wlog_addr[13'(n0)] !== 16'hF140 || wlog_data[13'(n0)] !== 16'h4320) begin
      errors++;
      $display("FAIL glyph_row4: writes %0d addr %h data %h required 1 F140 4320",
               wr_count - n0, wlog_addr[13'(n0)], wlog_data[13'(n0)]);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = wr_count;
    int not_ready = 0;
    logic [7:0] ch;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0:       ch = 8'h0A;
        1:       ch = 8'h0D;
        default: ch = 8'h08;
      endcase
      i_char_valid = 1'b1;
      i_char_data  = ch;
      if (!o_char_ready) not_ready++;
      @(negedge clk);
      model_char(ch);
      check_cursor("b2b_cursor");
    end
    i_char_valid = 1'b0;
    checks++;
    if (not_ready != 0 || wr_count != n0) begin
      errors++;
      $display("FAIL b2b_ready: ready-low %0d writes %0d required 0 0", not_ready, wr_count - n0);
    end
  endtask

  task automatic test_random();
    int b;
    logic [7:0] ch;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 19))
        0, 1:    ch = 8'h0A;
        2:       ch = 8'h0D;
        3:       ch = 8'h08;
        default: ch = rand_glyph();
      endcase
      send_char(ch, b);
      check_cursor("random_cursor");
    end
    check_screen("random_screen");
  endtask

  task automatic test_end_of_screen();
    int n0;
    int b;
    send_char(8'h0C, b);
    repeat (59) send_char(8'h0A, b);
    repeat (79) send_char(rand_glyph(), b);
    check_cursor("eos_at_79_59");
    n0 = wr_count;
    send_char(rand_glyph(), b);
    checks++;
`ifdef FB_TEXT_WRITER_SCROLL_EN
    if (wr_count - n0 != 2401 || wlog_addr[13'(n0)] !== 16'(32'hF000 + 80 * 59 + 39)
        || wlog_addr[13'(n0 + 1)] !== 16'hF000 || wlog_addr[13'(n0 + 2360)] !== 16'(32'hF000 + 80 * 58 + 39)) begin
      errors++;
      $display("FAIL scroll_copy: writes %0d first %h copy0 %h copyN %h required 2401 %h F000 %h",
               wr_count - n0, wlog_addr[13'(n0)], wlog_addr[13'(n0 + 1)], wlog_addr[13'(n0 + 2360)],
               16'(32'hF000 + 80 * 59 + 39), 16'(32'hF000 + 80 * 58 + 39));
    end
    checks++;
    if (wlog_addr[13'(n0 + 2361)] !== 16'(32'hF000 + 80 * 59) || wlog_data[13'(n0 + 2361)] !== 16'h2020
        || wlog_addr[13'(n0 + 2400)] !== 16'(32'hF000 + 80 * 59 + 39)) begin
      errors++;
      $display("FAIL scroll_fill: first %h data %h last %h required %h 2020 %h",
               wlog_addr[13'(n0 + 2361)], wlog_data[13'(n0 + 2361)], wlog_addr[13'(n0 + 2400)],
               16'(32'hF000 + 80 * 59), 16'(32'hF000 + 80 * 59 + 39));
    end
`else
    if (wr_count - n0 != 1 || wlog_addr[13'(n0)] !== 16'(32'hF000 + 80 * 59 + 39)) begin
      errors++;
      $display("FAIL wrap_write: writes %0d addr %h required 1 %h",
               wr_count - n0, wlog_addr[13'(n0)], 16'(32'hF000 + 80 * 59 + 39));
    end
`endif
    check_cursor("eos_cursor");
    check_screen("eos_screen");
  endtask

  task automatic test_reset_mid_clear();
    int n0 = wr_count;
    int n = 0;
    int n1;
    i_char_valid = 1'b1;
    i_char_data  = 8'h0C;
    @(negedge clk);
    i_char_valid = 1'b0;
    while (wr_count - n0 < 100 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (wr_count - n0 < 100) begin
      errors++;
      $display("FAIL midclr_progress: writes %0d required 100", wr_count - n0);
    end
    reset = 1'b1;
    @(negedge clk);
    m_col = 0;
    m_row = 0;
    checks++;
    if (o_mem_we !== 1'b0 || o_busy !== 1'b0 || o_char_ready !== 1'b0) begin
      errors++;
      $display("FAIL midclr_abort: we/busy/ready %b%b%b required 000", o_mem_we, o_busy, o_char_ready);
    end
    check_cursor("midclr_cursor");
    reset = 1'b0;
    #1;
    checks++;
    if (o_char_ready !== 1'b1) begin
      errors++;
      $display("FAIL midclr_ready: ready %b required 1", o_char_ready);
    end
    n1 = wr_count;
    repeat (5) @(negedge clk);
    checks++;
    if (wr_count != n1) begin
      errors++;
      $display("FAIL midclr_quiet: writes %0d after reset required 0", wr_count - n1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_backspace_home();
    test_clear();
    test_first_glyphs();
    test_newline_glyph();
    test_back_to_back();
    test_random();
    test_end_of_screen();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_text_writer.md
# fb_text_writer

- Upstream producer for the text-mode VGA frame buffer.
- Accepts a stream of 8-bit character codes over a valid/ready handshake and tracks an 80×60 glyph cursor.
- Packs each glyph into its byte of the 16-bit frame-buffer word at 0xF000+ with a read-modify-write, and handles newline, carriage return, backspace, clear-screen and end-of-screen behaviour.
- Drives one port of the frame-buffer RAM; the display address generator reads the other.

## Interface
- FB_BASE, 16'hF000, word address of glyph cell (0,0)
- ROW_STRIDE, 80, words between consecutive glyph rows
- COLS, 80, glyph columns per row (2 per word, 40 words used)
- ROWS, 60, glyph rows
- BLANK_GLYPH, 8'h20, code written by clear and scroll fill
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- char_valid  in  1  char_data valid
- char_data  in  8  character code, held stable until accepted
- char_ready  out  1  block can accept a code this cycle
- mem_addr  out  16  frame-buffer word address
- mem_wdata  out  16  write data
- mem_we  out  1  write strobe, one cycle per word
- mem_rdata  in  16  read data, valid one cycle after mem_addr is presented
- busy  out  1  not in IDLE
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  6  current row, 0..ROWS-1

## Operation
- Cell address: FB_BASE + ROW_STRIDE*row + col[6:1], 16-bit wrap. Even col maps to bits [15:8], odd col to bits [7:0].
- States: IDLE, RD, WR, CLR, SCR_RD, SCR_WR, SCR_CLR.
- IDLE: char_ready=1. Handshake is char_valid && char_ready at the clock edge. Decode on acceptance:
  - 0x0A: col←0, row advance, back to IDLE.
  - 0x0D: col←0.
  - 0x08: col←col-1 if col>0, else no change. No memory access.
  - 0x0C: enter CLR, zero the word counter.
  - Any other code: latch it, go to RD.
- RD: mem_addr = cell address, mem_we=0. Go to WR.
- WR: mem_wdata = mem_rdata with the target byte replaced by the code, mem_we=1. Then cursor advance: col+1; at col==COLS-1, col←0 and row advance. Go to IDLE, unless a scroll is triggered.
- Row advance:
  - row<ROWS-1: row+1.
  - row==ROWS-1: see Configuration.
- CLR: writes {BLANK_GLYPH,BLANK_GLYPH} to every used word, rows 0..ROWS-1 and words 0..COLS/2-1, one word per cycle. Cursor←(0,0). Then IDLE.
- Codes are never dropped. The producer holds char_data while char_ready=0.

## Timing
- Reset values: state IDLE, cursor (0,0), mem_we 0, mem_addr FB_BASE, mem_wdata 0, busy 0. char_ready is 0 in the reset cycle and 1 in the first cycle after reset deasserts.
- Reset mid-operation aborts at the next edge. Words already written stay written; no rollback.
- Printable code: accept edge, RD cycle, WR cycle. char_ready returns on the 3rd cycle after acceptance, giving a 3-cycle throughput.
- Control codes 0x0A/0x0D/0x08 without scroll: char_ready stays high. Back-to-back acceptance every cycle is allowed.
- Clear: ROWS*COLS/2 = 2400 write cycles, then IDLE.
- Scroll: (ROWS-1)*COLS/2*2 = 4720 cycles, plus COLS/2 = 40 cycles of blank fill. The triggering code's write completes before the scroll starts.
- cursor_col/cursor_row update on the same edge as the WR or control-code action.

## Configuration
- Macro: FB_TEXT_WRITER_SCROLL_EN.
- Defined, at row advance from ROWS-1:
  - SCR_RD/SCR_WR copy each word of row r+1 to row r, for r=0..ROWS-2: read in SCR_RD, write in SCR_WR the next cycle.
  - SCR_CLR then blanks row ROWS-1.
  - Cursor ends at (0,ROWS-1).
- Undefined, at row advance from ROWS-1: row←0, nothing cleared, SCR_* states absent from the design.

## Structure
- Package fb_text_pkg holds:
  - FB_BASE, ROW_STRIDE, COLS, ROWS, BLANK_GLYPH
  - control codes CH_LF/CH_CR/CH_BS/CH_FF
  - the state enum.
- Sub-module fb_cursor: col/row registers with inputs advance, newline, carriage_return, backspace, home. Outputs cursor position and an end-of-screen pulse for the scroll/wrap decision.

## Test plan
- Send 0x41 after reset with mem_rdata=16'h2020: one write to 16'hF000 with data 16'h4120; cursor becomes (1,0).
- Send 0x42 at cursor (1,0) with mem_rdata=16'h4120: one write to 16'hF000 with data 16'h4142; cursor becomes (2,0).
- Send 0x0A at (5,3), then 0x43: write to F000+80*4+0 = 16'hF140, byte [15:8]; no mem_we for the 0x0A.
- Send 0x08 at (0,0): cursor unchanged, no write. Send 0x0C: exactly 2400 writes of 16'h2020, cursor (0,0), char_ready low throughout.
- Write at (79,59) with the macro undefined: cursor becomes (0,0), no extra writes.
- Write at (79,59) with the macro defined: 2360 copy writes (row 1→0 first at 16'hF000, from 16'hF050), then 40 blank writes at F000+80*59; cursor becomes (0,59).
- Assert reset during the clear after 100 writes: mem_we drops at the next edge; cursor (0,0); char_ready is 1 in the first cycle after reset deasserts.
